button_repeat_conditioner: RTL

//   Front-end conditioner for the five board push-buttons (Up, Down, Left, Right, Centre).
//   - Synchronises and debounces each raw button.
//   - Produces a stable level, a one-cycle press pulse, a one-cycle release pulse, and

---
 rtl/button_repeat_conditioner_if.sv | 21 ++
 rtl/button_repeat_conditioner.sv | 135 +++++++++++++
 2 files changed

// File: rtl/button_repeat_conditioner_if.sv
// Button bundle between the raw board inputs and the conditioned outputs
// consumed by the function selector and step logic.
interface button_repeat_conditioner_if #(
  parameter int N_BTN = 5
);
  logic [N_BTN-1:0] Bt_raw;
  logic [N_BTN-1:0] Bt_level;
  logic [N_BTN-1:0] Bt_press;
  logic [N_BTN-1:0] Bt_release;
  logic [N_BTN-1:0] Bt_held;

  modport master (
    output Bt_raw,
    input  Bt_level, Bt_press, Bt_release, Bt_held
  );

  modport slave (
    input  Bt_raw,
    output Bt_level, Bt_press, Bt_release, Bt_held
  );
endinterface

// File: rtl/button_repeat_conditioner.sv
// Per-button synchroniser, debouncer and IDLE/HOLD/REPEAT auto-repeat FSM.
// Buttons are independent; all outputs are registered or decoded from registered state.
module button_repeat_conditioner #(
  parameter int               N_BTN         = 5,
  parameter int               SYNC_STAGES   = 2,
  parameter int               DEB_CYCLES    = 1_000_000,
  parameter int               HOLD_CYCLES   = 50_000_000,
  parameter int               REPEAT_CYCLES = 10_000_000,
  parameter logic [N_BTN-1:0] REPEAT_MASK   = 5'b01111
) (
  input  logic                          sysclk,
  input  logic                          Reset_n,
  button_repeat_conditioner_if.slave    bt
);

  localparam int DEB_W  = $clog2(DEB_CYCLES);
  localparam int HOLD_W = $clog2(HOLD_CYCLES);
  localparam int REP_W  = $clog2(REPEAT_CYCLES);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic [SYNC_STAGES-1:0] sync_q   [N_BTN];
  logic [DEB_W-1:0]       deb_cnt  [N_BTN];
  logic [HOLD_W-1:0]      hold_cnt [N_BTN];
  logic [REP_W-1:0]       rep_cnt  [N_BTN];
  logic [1:0]             state_q  [N_BTN];

  logic [N_BTN-1:0] level_q;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] release_q;

  logic [N_BTN-1:0] s_vec;
  logic [N_BTN-1:0] deb_done;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;
  logic [N_BTN-1:0] held_vec;

  // NOTE: every output of always_comb is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    s_vec    = '0;
    deb_done = '0;
    held_vec = '0;
    for (int i = 0; i < N_BTN; i++) begin
      s_vec[i]    = sync_q[i][SYNC_STAGES-1];
      deb_done[i] = (s_vec[i] != level_q[i]) && (deb_cnt[i] == DEB_LAST);
      held_vec[i] = (state_q[i] == ST_REPEAT);
    end
  end

  // A debounced toggle is a rise or a fall depending on the current level.
  assign rise = deb_done & ~level_q;
  assign fall = deb_done &  level_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sysclk or negedge Reset_n) begin
    if (!Reset_n) begin
      // NOTE: the per-button arrays are plain registers, not RAM, so each element is reset explicitly.
      for (int i = 0; i < N_BTN; i++) begin
        sync_q[i]   <= '0;
        deb_cnt[i]  <= '0;
        hold_cnt[i] <= '0;
        rep_cnt[i]  <= '0;
        state_q[i]  <= ST_IDLE;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], bt.Bt_raw[i]};

        if (s_vec[i] == level_q[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_done[i]) begin
          deb_cnt[i] <= '0;
          level_q[i] <= ~level_q[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end

        // A fall pre-empts any repeat that would fire in the same cycle.
        if (fall[i]) begin
          release_q[i] <= 1'b1;
          state_q[i]   <= ST_IDLE;
          hold_cnt[i]  <= '0;
          rep_cnt[i]   <= '0;
        end else begin
          case (state_q[i])
            ST_IDLE: begin
              if (rise[i]) begin
                press_q[i]  <= 1'b1;
                state_q[i]  <= ST_HOLD;
                hold_cnt[i] <= '0;
              end
            end
            ST_HOLD: begin
              if (hold_cnt[i] == HOLD_LAST) begin
                if (REPEAT_MASK[i]) begin
                  press_q[i] <= 1'b1;
                  state_q[i] <= ST_REPEAT;
                  rep_cnt[i] <= '0;
                end
              end else begin
                hold_cnt[i] <= hold_cnt[i] + 1'b1;
              end
            end
            ST_REPEAT: begin
              if (rep_cnt[i] == REP_LAST) begin
                press_q[i] <= 1'b1;
                rep_cnt[i] <= '0;
              end else begin
                rep_cnt[i] <= rep_cnt[i] + 1'b1;
              end
            end
            default: state_q[i] <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign bt.Bt_level   = level_q;
  assign bt.Bt_press   = press_q;
  assign bt.Bt_release = release_q;
  assign bt.Bt_held    = held_vec;

endmodule
